// File: rtl/alu_exec_unit.sv
`ifndef RoB_BITS
`define RoB_BITS 4
`endif

// Generic result FIFO: power-of-2 depth, synchronous flush, global hold via en.
// Latency: a pushed entry is visible at the read port the cycle after the push.
// Backpressure: full blocks pushes, empty blocks pops; flush beats both.
module alu_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [W-1:0]  mem [DEPTH];
    logic          push_fire;
    logic          pop_fire;

    assign pop_vld   = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_dat   = mem[head];
    assign push_fire = push_vld && !full;
    assign pop_fire  = pop_rdy && pop_vld;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            if (clr) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push_fire) begin
                    mem[tail] <= push_dat;
                    tail      <= tail + 1'b1;
                end
                if (pop_fire) begin
                    head <= head + 1'b1;
                end
                if (push_fire && !pop_fire) begin
                    count <= count + 1'b1;
                end else if (!push_fire && pop_fire) begin
                    count <= count - 1'b1;
                end
            end
        end
    end
endmodule

// Integer execution unit: evaluates one RS operation per cycle and queues {rob id, value} for the CDB.
// Latency: accept at edge N, finish_rdy and earliest CDB presentation in cycle N+1.
// Backpressure: req_ready low while the result FIFO is full or rdy_in is low; CDB head held until granted.
module alu_exec_unit #(
    parameter int ROB_BITS = `RoB_BITS,
    parameter int DEPTH    = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_in,
    input  logic                req_valid,
    input  logic [31:0]         req_vj,
    input  logic [31:0]         req_vk,
    input  logic [31:0]         req_imm,
    input  logic [5:0]          req_op,
    input  logic [ROB_BITS-1:0] req_dest,
    output logic                req_ready,
    output logic                finish_rdy,
    output logic                cdb_valid,
    output logic [ROB_BITS-1:0] cdb_id,
    output logic [31:0]         cdb_value,
    input  logic                cdb_grant
);
    localparam logic [1:0] TYPE_U = 2'd0;
    localparam logic [1:0] TYPE_I = 2'd1;
    localparam logic [1:0] TYPE_B = 2'd2;
    localparam logic [1:0] TYPE_R = 2'd3;
    localparam logic [5:0] OP_J   = 6'b111111;

    typedef struct packed {
        logic [ROB_BITS-1:0] id;
        logic [31:0]         value;
    } cdb_ent_t;

    logic [1:0]  op_type;
    logic [2:0]  funct3;
    logic        funct7b;
    logic [31:0] opnd_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        accept;
    logic        fifo_full;
    cdb_ent_t    push_ent;
    cdb_ent_t    head_ent;

    assign op_type = req_op[1:0];
    assign funct3  = req_op[4:2];
    assign funct7b = req_op[5];
    assign opnd_b  = (op_type == TYPE_I) ? req_imm : req_vk;
    assign shamt   = opnd_b[4:0];

    always_comb begin
        alu_res = '0;
        // J shares the R type code, so it must be decoded first.
        if (req_op == OP_J || op_type == TYPE_U) begin
            alu_res = req_imm;
        end else if (op_type == TYPE_B) begin
            case (funct3)
                3'b000:  alu_res = {31'd0, req_vj == req_vk};
                3'b001:  alu_res = {31'd0, req_vj != req_vk};
                3'b100:  alu_res = {31'd0, $signed(req_vj) <  $signed(req_vk)};
                3'b101:  alu_res = {31'd0, $signed(req_vj) >= $signed(req_vk)};
                3'b110:  alu_res = {31'd0, req_vj <  req_vk};
                3'b111:  alu_res = {31'd0, req_vj >= req_vk};
                default: alu_res = '0;
            endcase
        end else begin
            case (funct3)
                3'b000:  alu_res = (op_type == TYPE_R && funct7b) ? req_vj - opnd_b : req_vj + opnd_b;
                3'b001:  alu_res = req_vj << shamt;
                3'b010:  alu_res = {31'd0, $signed(req_vj) < $signed(opnd_b)};
                3'b011:  alu_res = {31'd0, req_vj < opnd_b};
                3'b100:  alu_res = req_vj ^ opnd_b;
                3'b101:  alu_res = funct7b ? $unsigned($signed(req_vj) >>> shamt) : req_vj >> shamt;
                3'b110:  alu_res = req_vj | opnd_b;
                default: alu_res = req_vj & opnd_b;
            endcase
        end
    end

    assign req_ready      = rdy_in && !fifo_full;
    assign accept         = req_valid && req_ready && !clear_in;
    assign push_ent.id    = req_dest;
    assign push_ent.value = alu_res;

    alu_result_fifo #(
        .W     ($bits(cdb_ent_t)),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk      (clk_in),
        .arst_n   (rst_in),
        .en       (rdy_in),
        .clr      (clear_in),
        .push_vld (accept),
        .push_dat (push_ent),
        .pop_rdy  (cdb_grant),
        .pop_vld  (cdb_valid),
        .pop_dat  (head_ent),
        .full     (fifo_full)
    );

    assign cdb_id    = head_ent.id;
    assign cdb_value = head_ent.value;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            finish_rdy <= 1'b0;
        end else if (rdy_in) begin
            finish_rdy <= accept;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: queue-based reference model checked every cycle, plus directed literal vectors.
module tb_alu_exec_unit;
    localparam int RB    = 4;
    localparam int DEPTH = 2;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear_in;
    logic          req_valid;
    logic [31:0]   req_vj;
    logic [31:0]   req_vk;
    logic [31:0]   req_imm;
    logic [5:0]    req_op;
    logic [RB-1:0] req_dest;
    logic          req_ready;
    logic          finish_rdy;
    logic          cdb_valid;
    logic [RB-1:0] cdb_id;
    logic [31:0]   cdb_value;
    logic          cdb_grant;

    always #5 clk_in = ~clk_in;

    alu_exec_unit #(.ROB_BITS(RB), .DEPTH(DEPTH)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear_in   (clear_in),
        .req_valid  (req_valid),
        .req_vj     (req_vj),
        .req_vk     (req_vk),
        .req_imm    (req_imm),
        .req_op     (req_op),
        .req_dest   (req_dest),
        .req_ready  (req_ready),
        .finish_rdy (finish_rdy),
        .cdb_valid  (cdb_valid),
        .cdb_id     (cdb_id),
        .cdb_value  (cdb_value),
        .cdb_grant  (cdb_grant)
    );

    int total  = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference semantics written from the instruction definitions.
    function automatic logic [31:0] golden(input logic [5:0] op, input logic [31:0] vj,
                                           input logic [31:0] vk, input logic [31:0] imm);
        logic [1:0]  ty;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] b;
        int unsigned s;
        ty = op[1:0];
        f3 = op[4:2];
        f7 = op[5];
        if (op == 6'h3f || ty == 2'd0) return imm;
        if (ty == 2'd2) begin
            case (f3)
                3'd0: return (vj == vk) ? 32'd1 : 32'd0;
                3'd1: return (vj != vk) ? 32'd1 : 32'd0;
                3'd4: return (int'(vj) <  int'(vk)) ? 32'd1 : 32'd0;
                3'd5: return (int'(vj) >= int'(vk)) ? 32'd1 : 32'd0;
                3'd6: return (vj <  vk) ? 32'd1 : 32'd0;
                3'd7: return (vj >= vk) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        b = (ty == 2'd1) ? imm : vk;
        s = b % 32;
        case (f3)
            3'd0: return (ty == 2'd3 && f7) ? vj - vk : vj + b;
            3'd1: return vj << s;
            3'd2: return (int'(vj) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (vj < b) ? 32'd1 : 32'd0;
            3'd4: return vj ^ b;
            3'd5: return f7 ? ((vj >> s) | (vj[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0)) : (vj >> s);
            3'd6: return vj | b;
            default: return vj & b;
        endcase
    endfunction

    typedef struct {
        logic [RB-1:0] id;
        logic [31:0]   val;
    } ent_t;

    ent_t mq[$];
    logic m_fin;
    bit   m_acc;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mq.delete();
            m_fin <= 1'b0;
        end else if (rdy_in) begin
            if (clear_in) begin
                mq.delete();
                m_fin <= 1'b0;
            end else begin
                m_acc = req_valid && (mq.size() < DEPTH);
                if (mq.size() > 0 && cdb_grant) void'(mq.pop_front());
                if (m_acc) mq.push_back('{req_dest, golden(req_op, req_vj, req_vk, req_imm)});
                m_fin <= m_acc;
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("m_cdb_valid", 32'(cdb_valid), 32'(mq.size() != 0));
            chk("m_req_ready", 32'(req_ready), 32'(rdy_in && mq.size() != DEPTH));
            chk("m_finish_rdy", 32'(finish_rdy), 32'(m_fin));
            if (mq.size() != 0) begin
                chk("m_cdb_id", 32'(cdb_id), 32'(mq[0].id));
                chk("m_cdb_value", cdb_value, mq[0].val);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [31:0] imm, input logic [RB-1:0] dest);
        req_valid = 1'b1;
        req_op    = op;
        req_vj    = vj;
        req_vk    = vk;
        req_imm   = imm;
        req_dest  = dest;
    endtask

    // Issue one op into an empty FIFO with grant high; result must be on the CDB for exactly one cycle.
    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [31:0] imm,
                          input logic [RB-1:0] dest, input logic [31:0] exp);
        set_req(op, vj, vk, imm, dest);
        step();
        req_valid = 1'b0;
        chk({name, "_finish"}, 32'(finish_rdy), 32'd1);
        chk({name, "_valid"}, 32'(cdb_valid), 32'd1);
        chk({name, "_id"}, 32'(cdb_id), 32'(dest));
        chk({name, "_value"}, cdb_value, exp);
        step();
        chk({name, "_drained"}, 32'(cdb_valid), 32'd0);
        chk({name, "_finish_off"}, 32'(finish_rdy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        clear_in  = 1'b0;
        req_valid = 1'b0;
        req_vj    = '0;
        req_vk    = '0;
        req_imm   = '0;
        req_op    = '0;
        req_dest  = '0;
        cdb_grant = 1'b0;
        #2;
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_finish", 32'(finish_rdy), 32'd0);
        chk("rst_cdb_id", 32'(cdb_id), 32'd0);
        chk("rst_cdb_value", cdb_value, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk_en = 1'b1;
        step();
        step();
        rst_in    = 1'b1;
        cdb_grant = 1'b1;

        run_op("add",      6'h03, 32'd5,          32'd7,          32'd0,          4'd3,  32'd12);
        run_op("sub",      6'h23, 32'd0,          32'd1,          32'd0,          4'd4,  32'hFFFF_FFFF);
        run_op("sra",      6'h37, 32'h8000_0000,  32'd4,          32'd0,          4'd5,  32'hF800_0000);
        run_op("srl",      6'h17, 32'h8000_0000,  32'd4,          32'd0,          4'd6,  32'h0800_0000);
        run_op("sltu",     6'h0F, 32'd1,          32'hFFFF_FFFF,  32'd0,          4'd7,  32'd1);
        run_op("slt",      6'h0B, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'd8,  32'd1);
        run_op("blt",      6'h12, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'd9,  32'd1);
        run_op("bltu",     6'h1A, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'd10, 32'd0);
        run_op("bne_eq",   6'h06, 32'd5,          32'd5,          32'd0,          4'd11, 32'd0);
        run_op("bgeu",     6'h1E, 32'd1,          32'hFFFF_FFFF,  32'd0,          4'd12, 32'd0);
        run_op("b_undef",  6'h0A, 32'd5,          32'd5,          32'd0,          4'd13, 32'd0);
        run_op("addi",     6'h01, 32'd10,         32'd99,         32'hFFFF_FFFD,  4'd14, 32'd7);
        run_op("slli",     6'h05, 32'd1,          32'd0,          32'd31,         4'd15, 32'h8000_0000);
        run_op("srai",     6'h35, 32'h8000_0000,  32'd0,          32'h0000_0404,  4'd1,  32'hF800_0000);
        run_op("jal",      6'h3F, 32'd77,         32'd88,         32'd1234,       4'd2,  32'd1234);
        run_op("lui",      6'h00, 32'd1,          32'd2,          32'hDEAD_B000,  4'd0,  32'hDEAD_B000);

        // Backpressure: three back-to-back requests with grant low.
        cdb_grant = 1'b0;
        set_req(6'h03, 32'd100, 32'd0, 32'd0, 4'd0);
        step();
        set_req(6'h03, 32'd101, 32'd0, 32'd0, 4'd1);
        step();
        set_req(6'h03, 32'd102, 32'd0, 32'd0, 4'd2);
        chk("bp_ready_full", 32'(req_ready), 32'd0);
        chk("bp_head_id0", 32'(cdb_id), 32'd0);
        step();
        chk("bp_held_ready", 32'(req_ready), 32'd0);
        chk("bp_held_finish", 32'(finish_rdy), 32'd0);
        chk("bp_held_value", cdb_value, 32'd100);
        cdb_grant = 1'b1;
        step();
        chk("bp_ready_back", 32'(req_ready), 32'd1);
        chk("bp_head_id1", 32'(cdb_id), 32'd1);
        step();
        req_valid = 1'b0;
        chk("bp_head_id2", 32'(cdb_id), 32'd2);
        chk("bp_finish3", 32'(finish_rdy), 32'd1);
        chk("bp_value2", cdb_value, 32'd102);
        step();
        chk("bp_drained", 32'(cdb_valid), 32'd0);

        // Flush with two queued entries and a pending request.
        cdb_grant = 1'b0;
        set_req(6'h03, 32'd1, 32'd1, 32'd0, 4'd1);
        step();
        set_req(6'h03, 32'd2, 32'd2, 32'd0, 4'd2);
        step();
        set_req(6'h03, 32'd3, 32'd3, 32'd0, 4'd3);
        clear_in = 1'b1;
        step();
        clear_in  = 1'b0;
        req_valid = 1'b0;
        chk("fl_valid", 32'(cdb_valid), 32'd0);
        chk("fl_finish", 32'(finish_rdy), 32'd0);
        chk("fl_ready", 32'(req_ready), 32'd1);
        // Flush must also drop a request that would otherwise have been accepted.
        set_req(6'h03, 32'd4, 32'd4, 32'd0, 4'd4);
        step();
        set_req(6'h03, 32'd5, 32'd5, 32'd0, 4'd5);
        clear_in = 1'b1;
        step();
        clear_in  = 1'b0;
        req_valid = 1'b0;
        chk("fl2_valid", 32'(cdb_valid), 32'd0);
        chk("fl2_finish", 32'(finish_rdy), 32'd0);
        step();
        chk("fl2_dropped", 32'(cdb_valid), 32'd0);

        // Stall: rdy_in low freezes outputs even with grant high.
        set_req(6'h03, 32'd20, 32'd22, 32'd0, 4'd9);
        step();
        req_valid = 1'b0;
        rdy_in    = 1'b0;
        cdb_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_finish", 32'(finish_rdy), 32'd1);
            chk("st_valid", 32'(cdb_valid), 32'd1);
            chk("st_id", 32'(cdb_id), 32'd9);
            chk("st_value", cdb_value, 32'd42);
            chk("st_ready", 32'(req_ready), 32'd0);
        end
        rdy_in = 1'b1;
        step();
        chk("st_popped", 32'(cdb_valid), 32'd0);
        chk("st_finish_off", 32'(finish_rdy), 32'd0);

        // Asynchronous reset mid-cycle with data queued.
        cdb_grant = 1'b0;
        set_req(6'h03, 32'd50, 32'd1, 32'd0, 4'd5);
        step();
        set_req(6'h03, 32'd60, 32'd1, 32'd0, 4'd6);
        step();
        req_valid = 1'b0;
        @(posedge clk_in);
        #3;
        rst_in = 1'b0;
        #1;
        chk("ar_valid", 32'(cdb_valid), 32'd0);
        chk("ar_finish", 32'(finish_rdy), 32'd0);
        chk("ar_id", 32'(cdb_id), 32'd0);
        chk("ar_value", cdb_value, 32'd0);
        step();
        rst_in    = 1'b1;
        cdb_grant = 1'b1;
        run_op("post_rst", 6'h1F, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 4'd7, 32'h00F0_00F0);

        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Integer execution unit at the consumer end of the reservation-station-to-ALU interface. It accepts one ready operation per cycle, evaluates it, and queues the result in a small FIFO. It then drives the result onto the common data bus (CDB) toward the RoB and the reservation stations. It also returns the per-operation completion pulse the reservation station uses to free its entry.

## Interface
Parameters:
- `ROB_BITS`, default `` `RoB_BITS `` (4): width of RoB ids.
- `DEPTH`, default 2: result FIFO depth; must be a power of 2, ≥2.

Ports:
- `clk_in`: input, 1 bit. System clock.
- `rst_in`: input, 1 bit. Reset, asynchronous, active-low.
- `rdy_in`: input, 1 bit. Global enable; all state holds when low.
- `clear_in`: input, 1 bit. Synchronous flush on branch mispredict.
- `req_valid`: input, 1 bit. The reservation station presents an operation.
- `req_vj`: input, 32 bits. Operand 1.
- `req_vk`: input, 32 bits. Operand 2.
- `req_imm`: input, 32 bits. Immediate. Already pc+imm for auipc.
- `req_op`: input, 6 bits. Encoded as {funct7bit, funct3, type}.
  - type 0 = U, 1 = I, 2 = B, 3 = R.
  - 6'b111111 = J.
- `req_dest`: input, `ROB_BITS` bits. RoB id of the result.
- `req_ready`: output, 1 bit. Combinational: `rdy_in && count != DEPTH`.
- `finish_rdy`: output, 1 bit. One-cycle pulse, cycle after acceptance.
- `cdb_valid`: output, 1 bit. FIFO head valid (`count != 0`).
- `cdb_id`: output, `ROB_BITS` bits. Head RoB id.
- `cdb_value`: output, 32 bits. Head result.
- `cdb_grant`: input, 1 bit. CDB arbiter consumes the head this cycle.

## Operation
- **Accept:** accept when `req_valid && req_ready` at posedge. Compute combinationally and push {dest, value} at the tail.
- **Pop:** pop when `cdb_valid && cdb_grant && rdy_in`.
- **Push and pop in the same cycle:** both happen, and `count` is unchanged. Push while full is impossible because `req_ready` is low.
- **No bypass:** an accepted result appears on the CDB no earlier than the next cycle.
- **Pointers:** head and tail are `log2(DEPTH)` bits and wrap modulo `DEPTH`. `count` is `log2(DEPTH)+1` bits.
- **Shift amounts:** R-type uses `req_vk[4:0]`; I-type uses `req_imm[4:0]`.
- **U-type:** result = `req_imm`.
- **J-type:** result = `req_imm`.
- **I-type and R-type, by funct3:**
  - 000: add. R-type only: sub when funct7bit = 1. I-type always adds `req_imm`, which also covers jalr target and load address.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra when funct7bit = 1.
  - 110: or.
  - 111: and.
- **B-type:** compares vj against vk; result = 32'd1 if taken, else 32'd0.
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - Other funct3 values give 0.
- **Arithmetic:** all 32-bit, wrap modulo 2^32, no overflow flag.
- **Flush (`clear_in`, when `rdy_in` is high):**
  - Head, tail and count go to 0, and `finish_rdy` goes to 0.
  - A request in the same cycle is dropped.
  - `clear_in` has priority over push and pop.
- **`rdy_in` low:**
  - No push, pop or flush.
  - `finish_rdy` holds its value.
  - CDB outputs stay stable.

## Timing
- **Reset (async assert):**
  - Head, tail and count are 0.
  - `finish_rdy` is 0, `cdb_valid` is 0, `cdb_id` is 0, `cdb_value` is 0.
  - FIFO storage is cleared to 0.
- **Reset deassert:** synchronous release; first acceptance possible at the first posedge after deassert.
- **Reset mid-operation:** all queued results are lost; outputs go to their reset values immediately.
- **Latency:** accept at edge N → `finish_rdy` high for cycle N+1 → result on the CDB from cycle N+1 if the FIFO was empty, otherwise after the earlier entries drain.
- **Throughput:** 1 op per cycle while `cdb_grant` stays high.
- **Grant with FIFO empty:** ignored.
- **CDB holding:** `cdb_id` and `cdb_value` hold until popped, independent of `req_*`.

## Test plan
- **Basic add:** reset, then `req_op` = {0,000,3}, vj = 5, vk = 7, dest = 3 with grant held high → `finish_rdy` pulses at N+1; the CDB shows id 3, value 12 for exactly one cycle.
- **Sub, sra and sltu:**
  - sub: vj = 0, vk = 1 → 32'hFFFFFFFF.
  - sra: vj = 32'h80000000, vk = 4 → 32'hF8000000.
  - sltu: vj = 1, vk = 32'hFFFFFFFF → 1.
- **Branches:** vj = -1, vk = 1.
  - blt → 1.
  - bltu → 0.
  - bne with equal operands → 0.
- **Backpressure:**
  - Grant low, issue 3 back-to-back requests → `req_ready` drops after 2 accepts; the third is held.
  - Raise grant → results pop in order (ids 0, 1, 2), and `req_ready` returns the cycle the first pop occurs.
- **Flush:** with 2 entries queued and a request presented, assert `clear_in` for 1 cycle → `cdb_valid` = 0 next cycle, no `finish_rdy`, and `req_ready` = 1.
- **Async reset and stall:**
  - Drop `rst_in` mid-cycle with data queued → `cdb_valid` and `finish_rdy` go to 0 immediately.
  - With `rdy_in` = 0 and grant high, outputs are frozen for 3 cycles.
